// File: rtl/tx8b10b_pkg.sv
// Shared types and constants for the 8b/10b transmit path.
package tx8b10b_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ONES_W = 4;

  localparam logic [CNT_W-1:0] LAST_BIT  = 4'd9;
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'h0FA;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'h305;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } tx_state_e;

  function automatic logic [ONES_W-1:0] popcount10(input logic [SYM_W-1:0] v);
    logic [ONES_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(SYM_W); i++) begin
      c = c + ONES_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/disp_check_10b.sv
// Running-disparity update and disparity-violation check for one 10-bit code group.
module disp_check_10b
  import tx8b10b_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  input  logic             rd_i,
  output logic             rd_o,
  output logic             err_o
);

  logic [ONES_W-1:0] ones;

  always_comb begin
    ones  = popcount10(sym_i);
    rd_o  = rd_i;
    err_o = 1'b0;
    if (ones > ONES_W'(5)) begin
      rd_o = 1'b1;
    end else if (ones < ONES_W'(5)) begin
      rd_o = 1'b0;
    end
    // Only 4/5/6-ones groups are legal, and unbalanced ones must oppose current RD.
    if ((ones < ONES_W'(4)) || (ones > ONES_W'(6))) begin
      err_o = 1'b1;
    end else if ((ones == ONES_W'(6)) && rd_i) begin
      err_o = 1'b1;
    end else if ((ones == ONES_W'(4)) && !rd_i) begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/serializer_10b.sv
// 10-bit code-group serializer with RD tracking and K28.5 idle insertion.
module serializer_10b
  import tx8b10b_pkg::*;
#(
  parameter logic        INIT_RD   = 1'b0,
  parameter int unsigned ERR_CHECK = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             VALID,
  output logic             READY,
  input  logic [SYM_W-1:0] SYM,
  output logic             TXD,
  output logic             SOS,
  output logic             IDLE,
  output logic             RD,
  output logic             ERR
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] shreg_q, shreg_d;
  logic             en_q;
  logic             idle_q, idle_d;
  logic             rd_q, rd_d;
  logic             err_q, err_d;

  logic             ready_c;
  logic [SYM_W-1:0] load_sym_c;
  logic             chk_rd_c;
  logic             chk_err_c;

  // Load slot: idle line or last bit of the current symbol, both gated by the registered enable.
  assign ready_c    = en_q & ((state_q == OFF) | ((state_q == RUN) & (cnt_q == LAST_BIT)));
  assign load_sym_c = VALID ? SYM : (rd_q ? K28_5_RDP : K28_5_RDN);

  disp_check_10b u_disp_check (
    .sym_i (load_sym_c),
    .rd_i  (rd_q),
    .rd_o  (chk_rd_c),
    .err_o (chk_err_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    idle_d  = idle_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    if (ready_c) begin
      state_d = RUN;
      cnt_d   = '0;
      shreg_d = load_sym_c;
      idle_d  = ~VALID;
      rd_d    = chk_rd_c;
      err_d   = VALID & chk_err_c & (ERR_CHECK != 0);
    end else if (state_q == RUN) begin
      if (cnt_q != LAST_BIT) begin
        cnt_d   = cnt_q + CNT_W'(1);
        shreg_d = shreg_q << 1;
      end else begin
        // Enable dropped: stop only after the last bit, leaving the line at 0.
        state_d = OFF;
        cnt_d   = '0;
        shreg_d = '0;
        idle_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= OFF;
      cnt_q   <= '0;
      shreg_q <= '0;
      en_q    <= 1'b0;
      idle_q  <= 1'b0;
      rd_q    <= INIT_RD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      en_q    <= EN;
      idle_q  <= idle_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign READY = ready_c;
  assign TXD   = shreg_q[SYM_W-1];
  assign SOS   = (state_q == RUN) & (cnt_q == '0);
  assign IDLE  = idle_q;
  assign RD    = rd_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_serializer_10b.sv
// Directed bench for serializer_10b; a second instance runs with ERR_CHECK=0.
module tb_serializer_10b;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       EN;
  logic       VALID;
  logic [9:0] SYM;

  logic a_ready, a_txd, a_sos, a_idle, a_rd, a_err;
  logic b_ready, b_txd, b_sos, b_idle, b_rd, b_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       vld;
    logic [9:0] sym;
    logic [9:0] bits;
    logic       idle;
    logic       rd;
    logic       err;
  } vec_t;

  serializer_10b #(.INIT_RD(1'b0), .ERR_CHECK(1)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .VALID(VALID), .READY(a_ready), .SYM(SYM),
    .TXD(a_txd), .SOS(a_sos), .IDLE(a_idle), .RD(a_rd), .ERR(a_err)
  );

  serializer_10b #(.INIT_RD(1'b0), .ERR_CHECK(0)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .VALID(VALID), .READY(b_ready), .SYM(SYM),
    .TXD(b_txd), .SOS(b_sos), .IDLE(b_idle), .RD(b_rd), .ERR(b_err)
  );

  always #5 CLK = ~CLK;

  // Observed vector order: {TXD, SOS, IDLE, RD, ERR, READY}
  task automatic test_reset();
    logic [5:0] obs;
    RSTN = 1'b0; EN = 1'b0; VALID = 1'b0; SYM = '0;
    repeat (3) @(negedge CLK);
    obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++; $display("FAIL reset_values obs=%b exp=%b", obs, 6'b000000);
    end
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++; $display("FAIL post_reset_en_low obs=%b exp=%b", obs, 6'b000000);
    end
  endtask

  task automatic test_enable_start();
    logic [5:0] obs;
    EN = 1'b1;
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_en_q obs=%b exp=0", a_ready);
    end
    @(negedge CLK);
    obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fail++; $display("FAIL enable_ready obs=%b exp=%b", obs, 6'b000001);
    end
  endtask

  task automatic test_symbol_stream();
    vec_t       tbl [11];
    logic [5:0] obs, exp;
    tbl = '{
      '{1'b0, 10'h000, 10'h0FA, 1'b1, 1'b1, 1'b0},
      '{1'b0, 10'h000, 10'h305, 1'b1, 1'b0, 1'b0},
      '{1'b1, 10'h2AA, 10'h2AA, 1'b0, 1'b0, 1'b0},
      '{1'b0, 10'h000, 10'h0FA, 1'b1, 1'b1, 1'b0},
      '{1'b1, 10'h0FA, 10'h0FA, 1'b0, 1'b1, 1'b1},
      '{1'b1, 10'h2AA, 10'h2AA, 1'b0, 1'b1, 1'b0},
      '{1'b0, 10'h000, 10'h305, 1'b1, 1'b0, 1'b0},
      '{1'b1, 10'h305, 10'h305, 1'b0, 1'b0, 1'b1},
      '{1'b1, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1},
      '{1'b1, 10'h305, 10'h305, 1'b0, 1'b0, 1'b0},
      '{1'b1, 10'h000, 10'h000, 1'b0, 1'b0, 1'b1}
    };
    for (int s = 0; s < 11; s++) begin
      VALID = tbl[s].vld;
      SYM   = tbl[s].sym;
      for (int b = 0; b < 10; b++) begin
        @(negedge CLK);
        VALID = 1'b0;
        exp = {tbl[s].bits[9-b], b == 0, tbl[s].idle, tbl[s].rd, tbl[s].err && (b == 0), b == 9};
        obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL stream sym%0d bit%0d obs=%b exp=%b", s, b, obs, exp);
        end
        n_checks++;
        if ({b_txd, b_rd, b_err} !== {tbl[s].bits[9-b], tbl[s].rd, 1'b0}) begin
          n_fail++;
          $display("FAIL nochk sym%0d bit%0d obs=%b exp=%b", s, b, {b_txd, b_rd, b_err},
                   {tbl[s].bits[9-b], tbl[s].rd, 1'b0});
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [5:0] obs, exp;
    logic [9:0] bits;
    bits  = 10'h2AA;
    VALID = 1'b1;
    SYM   = 10'h2AA;
    for (int b = 0; b < 10; b++) begin
      @(negedge CLK);
      SYM = 10'h0FA;
      if (b == 4) EN = 1'b0;
      exp = {bits[9-b], b == 0, 1'b0, 1'b0, 1'b0, 1'b0};
      obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL drop_tail bit%0d obs=%b exp=%b", b, obs, exp);
      end
    end
    repeat (5) begin
      @(negedge CLK);
      obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
      n_checks++;
      if (obs !== 6'b000000) begin
        n_fail++; $display("FAIL drop_off obs=%b exp=%b", obs, 6'b000000);
      end
    end
    EN = 1'b1;
    @(negedge CLK);
    obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fail++; $display("FAIL reenable_ready obs=%b exp=%b", obs, 6'b000001);
    end
    bits = 10'h0FA;
    for (int b = 0; b < 10; b++) begin
      @(negedge CLK);
      VALID = 1'b0;
      exp = {bits[9-b], b == 0, 1'b0, 1'b1, 1'b0, b == 9};
      obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL reenable_sym bit%0d obs=%b exp=%b", b, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    logic [5:0] obs, exp;
    logic [9:0] bits;
    VALID = 1'b1;
    SYM   = 10'h3FF;
    for (int b = 0; b < 7; b++) begin
      @(negedge CLK);
      VALID = 1'b0;
      exp = {1'b1, b == 0, 1'b0, 1'b1, b == 0, 1'b0};
      obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL pre_reset bit%0d obs=%b exp=%b", b, obs, exp);
      end
    end
    RSTN = 1'b0;
    #1;
    obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++; $display("FAIL async_reset obs=%b exp=%b", obs, 6'b000000);
    end
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fail++; $display("FAIL post_reset_ready obs=%b exp=%b", obs, 6'b000001);
    end
    bits = 10'h0FA;
    for (int b = 0; b < 10; b++) begin
      @(negedge CLK);
      exp = {bits[9-b], b == 0, 1'b1, 1'b1, 1'b0, b == 9};
      obs = {a_txd, a_sos, a_idle, a_rd, a_err, a_ready};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL post_reset_comma bit%0d obs=%b exp=%b", b, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_start();
    test_symbol_stream();
    test_enable_drop();
    test_reset_mid_symbol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
